// File: rtl/ffq_winner_latch_pkg.sv
// Shared definitions for the fastest-finger-first winner latch.
package ffq_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] NO_PRESS = 4'hF;

  // Round states; the encoding is visible on the debug output.
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_QUALIFY  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_TIMEOUT  = 3'd4
  } ffq_state_t;

  // True in the states where the round is open and watching for a press.
  function automatic logic is_armed_state(input ffq_state_t s);
    return (s == ST_ARMED) || (s == ST_QUALIFY);
  endfunction

  // True in the states where a winner is held.
  function automatic logic is_winner_state(input ffq_state_t s);
    return (s == ST_LOCKED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/ffq_winner_latch_if.sv
// Quizmaster/encoder inputs and display outputs of the winner latch.
interface ffq_winner_latch_if;
  import ffq_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              arm;
  logic              clear;
  logic [CODE_W-1:0] winner_code;
  logic              winner_valid;
  logic              armed;
  logic              buzzer;
  logic              timeout;
  logic              false_start;
  logic [2:0]        state_o;

  modport master (
    output code_in, arm, clear,
    input  winner_code, winner_valid, armed, buzzer, timeout, false_start, state_o
  );

  modport slave (
    input  code_in, arm, clear,
    output winner_code, winner_valid, armed, buzzer, timeout, false_start, state_o
  );

endinterface

// File: rtl/ffq_winner_latch_sync.sv
// N-bit two-flop synchronizer with a configurable reset value.
module ffq_sync #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ffq_winner_latch.sv
// Qualifies the encoder code, latches the first contestant and runs the
// buzzer and answer-time counters until the quizmaster clears the round.
module ffq_winner_latch
  import ffq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BUZZ_CYC     = 8,
  parameter int ANSWER_CYC   = 32
) (
  input  logic               clk,
  input  logic               rst,
  ffq_winner_latch_if.slave  bus
);

  localparam int QW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BW = $clog2(BUZZ_CYC + 1);
  localparam int AW = $clog2(ANSWER_CYC + 1);
  localparam logic [QW-1:0] DEB_LAST = QW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BUZZ_LD  = BW'(BUZZ_CYC);
  localparam logic [AW-1:0] ANS_LD   = AW'(ANSWER_CYC);

  logic [CODE_W-1:0] code_s;

  ffq_state_t        state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [AW-1:0]     acnt_q, acnt_d;
  logic [CODE_W-1:0] winner_code_q, winner_code_d;
  logic              buzzer_q, buzzer_d;
  logic              false_start_q, false_start_d;
  logic              armed_q, winner_valid_q, timeout_q;

  ffq_sync #(.W(CODE_W), .RST_VAL(NO_PRESS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.code_in),
    .q_o (code_s)
  );

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    qcnt_d        = qcnt_q;
    bcnt_d        = bcnt_q;
    acnt_d        = acnt_q;
    winner_code_d = winner_code_q;
    buzzer_d      = buzzer_q;
    false_start_d = 1'b0;
    if (bus.clear) begin
      state_d       = ST_DISARMED;
      cand_d        = NO_PRESS;
      qcnt_d        = '0;
      bcnt_d        = '0;
      acnt_d        = '0;
      winner_code_d = NO_PRESS;
      buzzer_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (bus.arm && (code_s == NO_PRESS)) begin
            state_d = ST_ARMED;
          end else if (bus.arm) begin
            false_start_d = 1'b1;
          end else begin
            state_d = ST_DISARMED;
          end
        end
        ST_ARMED: begin
          if (code_s != NO_PRESS) begin
            cand_d = code_s;
            if (DEBOUNCE_CYC == 1) begin
              state_d       = ST_LOCKED;
              winner_code_d = code_s;
              buzzer_d      = 1'b1;
              bcnt_d        = BUZZ_LD;
              acnt_d        = ANS_LD;
              qcnt_d        = '0;
            end else begin
              state_d = ST_QUALIFY;
              qcnt_d  = QW'(1);
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_QUALIFY: begin
          if (code_s == NO_PRESS) begin
            // Glitch or early release: back to waiting.
            state_d = ST_ARMED;
            qcnt_d  = '0;
          end else if (code_s == cand_q) begin
            if (qcnt_q >= DEB_LAST) begin
              state_d       = ST_LOCKED;
              winner_code_d = cand_q;
              buzzer_d      = 1'b1;
              bcnt_d        = BUZZ_LD;
              acnt_d        = ANS_LD;
              qcnt_d        = '0;
            end else begin
              qcnt_d = qcnt_q + QW'(1);
            end
          end else begin
            // A different contestant code: restart qualification on it.
            cand_d = code_s;
            qcnt_d = QW'(1);
          end
        end
        ST_LOCKED: begin
          // Both counters count down and saturate at zero.
          if (bcnt_q > BW'(1)) begin
            bcnt_d   = bcnt_q - BW'(1);
            buzzer_d = 1'b1;
          end else begin
            bcnt_d   = '0;
            buzzer_d = 1'b0;
          end
          if (acnt_q > AW'(1)) begin
            acnt_d = acnt_q - AW'(1);
          end else begin
            acnt_d   = '0;
            buzzer_d = 1'b0;
            state_d  = ST_TIMEOUT;
          end
        end
        ST_TIMEOUT: begin
          state_d  = ST_TIMEOUT;
          buzzer_d = 1'b0;
        end
        default: begin
          state_d       = ST_DISARMED;
          winner_code_d = NO_PRESS;
          buzzer_d      = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_DISARMED;
      cand_q         <= NO_PRESS;
      qcnt_q         <= '0;
      bcnt_q         <= '0;
      acnt_q         <= '0;
      winner_code_q  <= NO_PRESS;
      buzzer_q       <= 1'b0;
      false_start_q  <= 1'b0;
      armed_q        <= 1'b0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      qcnt_q         <= qcnt_d;
      bcnt_q         <= bcnt_d;
      acnt_q         <= acnt_d;
      winner_code_q  <= winner_code_d;
      buzzer_q       <= buzzer_d;
      false_start_q  <= false_start_d;
      armed_q        <= is_armed_state(state_d);
      winner_valid_q <= is_winner_state(state_d);
      timeout_q      <= (state_d == ST_TIMEOUT);
    end
  end

  assign bus.winner_code  = winner_code_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.armed        = armed_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.timeout      = timeout_q;
  assign bus.false_start  = false_start_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_ffq_winner_latch.sv
// Directed bench for ffq_winner_latch with a round-level reference model.
module tb_ffq_winner_latch;

  localparam int DEB  = 4;
  localparam int BUZZ = 8;
  localparam int ANS  = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ffq_winner_latch_if bus ();

  ffq_winner_latch #(.DEBOUNCE_CYC(DEB), .BUZZ_CYC(BUZZ), .ANSWER_CYC(ANS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the contestant code seen two edges late, the length of
  // the current run of one non-idle code, and the age of the latched win.
  int         m_phase;   // 0 closed, 1 open, 2 won
  int         m_run;
  logic [3:0] m_cand;
  logic [3:0] m_win;
  int         m_since;
  logic       m_fs;
  logic [3:0] m_pipe1, m_pipe2;

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_cand = 4'hF; m_win = 4'hF;
    m_since = 0; m_fs = 1'b0; m_pipe1 = 4'hF; m_pipe2 = 4'hF;
  endtask

  task automatic model_step();
    logic [3:0] seen;
    seen    = m_pipe2;
    m_pipe2 = m_pipe1;
    m_pipe1 = bus.code_in;
    m_fs    = 1'b0;
    if (bus.clear) begin
      m_phase = 0; m_run = 0; m_win = 4'hF;
    end else if (m_phase == 0) begin
      if (bus.arm && seen == 4'hF) begin
        m_phase = 1; m_run = 0;
      end else begin
        m_fs = bus.arm;
      end
    end else if (m_phase == 1) begin
      if (seen == 4'hF) m_run = 0;
      else if (m_run > 0 && seen == m_cand) m_run = m_run + 1;
      else begin m_cand = seen; m_run = 1; end
      if (m_run >= DEB) begin
        m_phase = 2; m_win = m_cand; m_since = 0; m_run = 0;
      end
    end else begin
      if (m_since < 1000) m_since = m_since + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  function automatic logic [2:0] exp_state();
    if (m_phase == 0) return 3'd0;
    if (m_phase == 1) return (m_run == 0) ? 3'd1 : 3'd2;
    return (m_since >= ANS) ? 3'd4 : 3'd3;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_state",  {5'd0, bus.state_o}, {5'd0, exp_state()});
      chk("m_code",   {4'd0, bus.winner_code}, {4'd0, (m_phase == 2) ? m_win : 4'hF});
      chk("m_valid",  {7'd0, bus.winner_valid}, {7'd0, m_phase == 2});
      chk("m_armed",  {7'd0, bus.armed}, {7'd0, m_phase == 1});
      chk("m_buzzer", {7'd0, bus.buzzer}, {7'd0, m_phase == 2 && m_since < BUZZ});
      chk("m_tmo",    {7'd0, bus.timeout}, {7'd0, m_phase == 2 && m_since >= ANS});
      chk("m_fs",     {7'd0, bus.false_start}, {7'd0, m_fs});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; tick(1); bus.clear = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {5'd0, bus.state_o}, 8'd0);
    chk({tag, "_code"},  {4'd0, bus.winner_code}, 8'h0F);
    chk({tag, "_flags"}, {3'd0, bus.winner_valid, bus.armed, bus.buzzer,
                          bus.timeout, bus.false_start}, 8'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    bus.code_in = 4'hF; bus.arm = 1'b0; bus.clear = 1'b0;
    rst = 1'b1;
    #12 rst = 1'b0;
    tick(1);
    chk_reset_vals("rst");

    // Clean press on 5: lock six edges after the change, buzz 8, timeout at 32.
    pulse_arm();
    chk("arm_armed", {7'd0, bus.armed}, 8'd1);
    bus.code_in = 4'h5;
    tick(5);
    chk("pre_lock_valid", {7'd0, bus.winner_valid}, 8'd0);
    tick(1);
    chk("lock_valid", {7'd0, bus.winner_valid}, 8'd1);
    chk("lock_code", {4'd0, bus.winner_code}, 8'h05);
    chk("lock_buzz", {7'd0, bus.buzzer}, 8'd1);
    tick(7);
    chk("buzz_last", {7'd0, bus.buzzer}, 8'd1);
    tick(1);
    chk("buzz_off", {7'd0, bus.buzzer}, 8'd0);
    tick(23);
    chk("pre_timeout", {7'd0, bus.timeout}, 8'd0);
    tick(1);
    chk("timeout", {7'd0, bus.timeout}, 8'd1);
    chk("timeout_state", {5'd0, bus.state_o}, 8'd4);
    chk("timeout_valid", {7'd0, bus.winner_valid}, 8'd1);

    // Short glitch on 6 is rejected; then 7 held wins.
    bus.code_in = 4'hF;
    pulse_clear();
    tick(3);
    pulse_arm();
    bus.code_in = 4'h6; tick(2);
    bus.code_in = 4'hF; tick(6);
    chk("glitch_state", {5'd0, bus.state_o}, 8'd1);
    bus.code_in = 4'h7; tick(6);
    chk("win7_code", {4'd0, bus.winner_code}, 8'h07);

    // Lock on 5 and hold it while other buttons change; clear empties it.
    bus.code_in = 4'hF; pulse_clear(); tick(3);
    pulse_arm();
    bus.code_in = 4'h5; tick(6);
    bus.code_in = 4'h6; tick(2);
    bus.code_in = 4'h8; tick(3);
    chk("hold_code", {4'd0, bus.winner_code}, 8'h05);
    pulse_clear();
    chk("clr_code", {4'd0, bus.winner_code}, 8'h0F);
    chk("clr_state", {5'd0, bus.state_o}, 8'd0);

    // Button held during arm: false start.
    bus.code_in = 4'h4; tick(3);
    pulse_arm();
    chk("fs_pulse", {7'd0, bus.false_start}, 8'd1);
    chk("fs_armed", {7'd0, bus.armed}, 8'd0);
    tick(1);
    chk("fs_drop", {7'd0, bus.false_start}, 8'd0);
    bus.code_in = 4'hF; tick(3);
    pulse_arm();
    chk("rearm", {7'd0, bus.armed}, 8'd1);

    // arm together with clear while closed; clear on the completing edge.
    pulse_clear();
    bus.arm = 1'b1; bus.clear = 1'b1; tick(1);
    bus.arm = 1'b0; bus.clear = 1'b0;
    chk("armclr_state", {5'd0, bus.state_o}, 8'd0);
    pulse_arm();
    bus.code_in = 4'h3; tick(5);
    bus.clear = 1'b1; tick(1); bus.clear = 1'b0;
    chk("clrlock_state", {5'd0, bus.state_o}, 8'd0);
    chk("clrlock_valid", {7'd0, bus.winner_valid}, 8'd0);
    bus.code_in = 4'hF; tick(3);

    // Async reset in the middle of qualification.
    pulse_arm();
    bus.code_in = 4'h2; tick(3);
    chk("qual_state", {5'd0, bus.state_o}, 8'd2);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rstq");
    @(posedge clk); #1 rst = 1'b0;
    tick(8);
    chk("held_no_lock", {7'd0, bus.winner_valid}, 8'd0);

    // Async reset while locked.
    bus.code_in = 4'hF; tick(3);
    pulse_arm();
    bus.code_in = 4'h9; tick(7);
    chk("lock9_valid", {7'd0, bus.winner_valid}, 8'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rstl");
    @(posedge clk); #1 rst = 1'b0;
    bus.code_in = 4'hF;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
